// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the trace capture block: capture state
// encoding, the "no point" read value and the ADC code width.
package trace_capture_pkg;

  localparam int unsigned ADC_W    = 16;
  localparam logic [9:0]  NO_POINT = 10'h3FF;

  typedef enum logic [1:0] {
    ST_ROLL    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/trace_capture_decim.sv
// Sample decimator and screen-row scaling. Counts accepted samples and emits
// one point (combinationally, in the cycle of the DECIM-th sample) carrying
// both the scaled screen row and the raw code for trigger detection.
module trace_decim
  import trace_capture_pkg::*;
#(
  parameter int unsigned DECIM    = 1000,
  parameter int unsigned Y_BOTTOM = 525,
  parameter int unsigned Y_SPAN   = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample_data,
  output logic             pt_valid,
  output logic [9:0]       pt_y,
  output logic [ADC_W-1:0] pt_code
);

  localparam int unsigned      CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0] cnt;
  logic [25:0]      product;

  // Accepted-sample counter, wrapping after DECIM samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sample_valid) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Point emission and code-to-row scaling
  always_comb begin
    product  = 26'(sample_data) * 26'(Y_SPAN);
    pt_y     = 10'(Y_BOTTOM) - product[25:16];
    pt_valid = sample_valid && (cnt == CNT_LAST);
    pt_code  = sample_data;
  end

endmodule

// File: rtl/trace_capture.sv
// Trace capture: decimated ADC points into a circular column buffer with a
// registered newest-relative read port. Define TRACE_CAPTURE_TRIGGER_EN to
// build the ARMED/CAPTURE/HOLD trigger sequencer; otherwise the buffer rolls
// continuously and state stays ROLL.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH    = 600,
  parameter int unsigned DECIM    = 1000,
  parameter int unsigned Y_BOTTOM = 525,
  parameter int unsigned Y_SPAN   = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample_data,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             rearm,
  input  logic [9:0]       rd_addr,
  output logic [9:0]       rd_y,
  output logic [1:0]       state,
  output logic             frame_done
);

  localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       FILL_W   = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic             pt_valid;
  logic [9:0]       pt_y;
  logic [ADC_W-1:0] pt_code;
  logic [9:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [FILL_W-1:0] fill;
  logic             wr_en;
  logic [11:0]      rd_sum;
  logic [11:0]      rd_phys;
  logic             rd_hit;

  trace_decim #(
    .DECIM    (DECIM),
    .Y_BOTTOM (Y_BOTTOM),
    .Y_SPAN   (Y_SPAN)
  ) u_decim (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .pt_valid     (pt_valid),
    .pt_y         (pt_y),
    .pt_code      (pt_code)
  );

  // Map newest-relative column to a physical slot; a single conditional
  // subtract suffices since rd_addr is only used when below DEPTH
  always_comb begin
    rd_sum  = 12'(wr_ptr) + 12'(DEPTH) - 12'd1 - 12'(rd_addr);
    rd_phys = (rd_sum >= 12'(DEPTH)) ? rd_sum - 12'(DEPTH) : rd_sum;
    rd_hit  = (12'(rd_addr) < 12'(DEPTH)) && (12'(rd_addr) < 12'(fill));
  end

  // Trace storage; never cleared, stale slots are masked by the fill count
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= pt_y;
    end
  end

  // Registered read-first column lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_y <= NO_POINT;
    end else begin
      rd_y <= rd_hit ? mem[rd_phys[PTR_W-1:0]] : NO_POINT;
    end
  end

  // Write pointer and saturating fill count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

`ifdef TRACE_CAPTURE_TRIGGER_EN
  state_t            state_q;
  logic [ADC_W-1:0]  prev_code;
  logic [FILL_W-1:0] cap_cnt;
  logic              trig_hit;

  assign trig_hit = pt_valid && (prev_code < trig_level) && (pt_code >= trig_level);
  assign wr_en    = pt_valid && !rst && (state_q != ST_HOLD);
  assign state    = state_q;

  // Capture sequencer: arm, take DEPTH points from the crossing, hold until rearm
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARMED;
      prev_code  <= '0;
      cap_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pt_valid) begin
        prev_code <= pt_code;
      end
      case (state_q)
        ST_ARMED: begin
          if (trig_hit) begin
            cap_cnt <= FILL_W'(1);
            if (DEPTH == 1) begin
              state_q    <= ST_HOLD;
              frame_done <= 1'b1;
            end else begin
              state_q <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (pt_valid) begin
            cap_cnt <= cap_cnt + FILL_W'(1);
            if (cap_cnt == FILL_MAX - FILL_W'(1)) begin
              state_q    <= ST_HOLD;
              frame_done <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (rearm) begin
            state_q <= ST_ARMED;
          end
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end
`else
  logic unused_inputs;

  assign wr_en         = pt_valid && !rst;
  assign state         = ST_ROLL;
  assign frame_done    = 1'b0;
  assign unused_inputs = ^{trig_level, rearm, pt_code};
`endif

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: a queue-based history model predicts
// rd_y, state and frame_done for every cycle; a monitor compares on negedge.
module tb_trace_capture;

  localparam int DEPTH    = 8;
  localparam int DECIM    = 3;
  localparam int Y_BOTTOM = 525;
  localparam int Y_SPAN   = 480;
`ifdef TRACE_CAPTURE_TRIGGER_EN
  localparam int RESET_ST = 1;
`else
  localparam int RESET_ST = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [15:0] trig_level;
  logic        rearm;
  logic [9:0]  rd_addr;
  logic [9:0]  rd_y;
  logic [1:0]  state;
  logic        frame_done;

  always #5 clk = ~clk;

  trace_capture #(
    .DEPTH    (DEPTH),
    .DECIM    (DECIM),
    .Y_BOTTOM (Y_BOTTOM),
    .Y_SPAN   (Y_SPAN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .rearm        (rearm),
    .rd_addr      (rd_addr),
    .rd_y         (rd_y),
    .state        (state),
    .frame_done   (frame_done)
  );

  typedef struct {
    logic [9:0] y;
    logic [1:0] st;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: newest-first list of stored rows plus trigger bookkeeping
  int hist[$];
  int dcnt = 0;
  int prev = 0;
  int mst  = RESET_ST;
  int ncap = 0;

  function automatic int row_of(input int code);
    return Y_BOTTOM - (code * Y_SPAN) / 65536;
  endfunction

  task automatic step(input bit r, input bit v, input int code, input int trig,
                      input bit ra, input int addr);
    exp_t e;
    bit   pt;
    bit   mfd;
    rst          = r;
    sample_valid = v;
    sample_data  = 16'(code);
    trig_level   = 16'(trig);
    rearm        = ra;
    rd_addr      = 10'(addr);
    e.y = (!r && addr < hist.size()) ? 10'(hist[addr]) : 10'h3FF;
    mfd = 1'b0;
    if (r) begin
      hist.delete();
      dcnt = 0;
      prev = 0;
      mst  = RESET_ST;
      ncap = 0;
    end else begin
      pt = v && (dcnt == DECIM - 1);
      if (v) dcnt = (dcnt + 1) % DECIM;
`ifdef TRACE_CAPTURE_TRIGGER_EN
      if (mst == 3) begin
        if (ra) mst = 1;
      end else if (pt) begin
        hist.push_front(row_of(code));
        if (mst == 1 && prev < trig && code >= trig) begin
          mst  = 2;
          ncap = 1;
        end else if (mst == 2) begin
          ncap++;
          if (ncap == DEPTH) begin
            mst = 3;
            mfd = 1'b1;
          end
        end
      end
      if (pt) prev = code;
`else
      if (pt) hist.push_front(row_of(code));
`endif
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    e.st = 2'(mst);
    e.fd = mfd;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  // Monitor: one expectation becomes visible after each active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (rd_y !== e.y) begin
          n_err++;
          $display("FAIL rd_y t=%0t addr=%0d got %0d required %0d", $time, rd_addr, rd_y, e.y);
        end
        n_vec++;
        if (state !== e.st) begin
          n_err++;
          $display("FAIL state t=%0t got %0d required %0d", $time, state, e.st);
        end
        n_vec++;
        if (frame_done !== e.fd) begin
          n_err++;
          $display("FAIL frame_done t=%0t got %0b required %0b", $time, frame_done, e.fd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    bit v;
    bit ra;
    int code;
    int trig;
    int addr;
    int ramp;
    ramp = 0;

    repeat (2) step(1, 0, 0, 'h4000, 0, 0);
    // Decimation and code 0 -> row 525
    for (int i = 0; i < 9; i++) step(0, 1, 0, 'h4000, 0, 0);
    // Full-scale and mid-scale rows
    for (int i = 0; i < 3; i++) step(0, 1, 'hFFFF, 'h4000, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 'h8000, 'h4000, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 'h4000, 0, i);
    // Reset after a few points masks all columns
    step(1, 0, 0, 'h4000, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 'h1000, 'h4000, 0, 0);
    step(1, 1, 'h1000, 'h4000, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 'h4000, 0, i);

    // Randomized ramps with wrap-around crossings, rearms and rare resets
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 599) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        code = int'($urandom_range(0, 65535));
      end else begin
        ramp = (ramp + int'($urandom_range(0, 3000))) % 65536;
        code = ramp;
      end
      trig = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 65535)) : 'h4000;
      ra   = ($urandom_range(0, 15) == 0);
      addr = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 1023))
                                          : int'($urandom_range(0, DEPTH + 2));
      step(r, v, code, trig, ra, addr);
    end

    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 'h4000, 0, i);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
